multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, the maximum consecutive memory stall cycles tolerated before error.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports op_i  input  6  (instr[31:26]) and funct_i  input  6  (instr[5:0]), both sampled from the instruction register.
REQ-005 SHALL have ports zero_i  input  1  (ALU zero flag) and mem_ready_i  input  1  (memory access completes this cycle).
REQ-006 SHALL have outputs pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o, reg_write_o, alu_src_a_o  output  1 each  (datapath enables/selects).
REQ-007 SHALL have outputs reg_dst_o (0 rt, 1 rd, 2 r31), mem_to_reg_o (0 ALUOut, 1 MDR, 2 PC), alu_src_b_o (0 regB, 1 const 4, 2 signext, 3 signext<<2), and pc_source_o (0 ALU, 1 ALUOut, 2 jump addr, 3 rs), each  output  2.
REQ-008 SHALL have output alu_op_o  output  3  (000 add, 001 sub, 010 use funct).
REQ-009 SHALL have outputs state_o  output  4 (state code), instr_done_o  output  1, illegal_o  output  1, err_o  output  1, and instr_cnt_o  output  32.

Function
REQ-010 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, ERR=12; any unlisted output value is 0.
REQ-011 FETCH SHALL drive iord=0, mem_read=1, src_a=0, src_b=1, alu_op=add; pc_write=1, ir_write=1 and pc_source=0 only in the cycle mem_ready_i=1; on mem_ready_i=1 go to DECODE, else stay.
REQ-012 DECODE SHALL drive src_a=0, src_b=3, alu_op=add, with next state: op 100011/101011 -> MEMADR; op 000000 with funct 001000 -> JUMP; other op 000000 -> EXEC; 000100/000101 -> BRANCH; 000010/000011 -> JUMP; 001000 -> IEXEC.
REQ-013 In DECODE, any other opcode SHALL pulse illegal_o for one cycle, cause no writes, and go to FETCH with instr_done_o=1.
REQ-014 MEMADR SHALL drive src_a=1, src_b=2, alu_op=add and go to MEMRD (lw) or MEMWR (sw).
REQ-015 MEMRD SHALL drive iord=1 and mem_read=1 until mem_ready_i=1, then go to MEMWB.
REQ-016 MEMWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=1.
REQ-017 MEMWR SHALL drive iord=1 and mem_write=1 held until mem_ready_i=1, then go to FETCH.
REQ-018 EXEC SHALL drive src_a=1, src_b=0, alu_op=010 and go to RWB; RWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-019 IEXEC SHALL drive src_a=1, src_b=2, alu_op=add and go to IWB; IWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-020 BRANCH SHALL drive src_a=1, src_b=0, alu_op=sub, pc_source=1, with pc_write = (beq & zero_i) | (bne & ~zero_i).
REQ-021 JUMP SHALL drive pc_write=1, with pc_source=2 for j/jal and 3 for jr.
REQ-022 For jal, JUMP SHALL also drive reg_write=1, reg_dst=2, mem_to_reg=2; the PC already holds PC+4.
REQ-023 MEMWB, MEMWR (on ready), RWB, IWB, BRANCH and JUMP SHALL be final states that go to FETCH and assert instr_done_o=1 for that one cycle.
REQ-024 instr_cnt_o SHALL increment by 1 on each instr_done_o cycle and wrap from 0xFFFFFFFF to 0.
REQ-025 A wait counter SHALL clear on entry to FETCH/MEMRD/MEMWR, increment on each cycle in those states with mem_ready_i=0, and force a transition to ERR on the cycle it would exceed WAIT_MAX.
REQ-026 ERR SHALL force all enables to 0 and err_o=1, and is sticky until reset.
REQ-027 mem_ready_i SHALL be ignored in states without a memory access.
REQ-028 op_i, funct_i and zero_i SHALL be combinational inputs used only in DECODE, MEMADR, JUMP and BRANCH.

Reset
REQ-029 With rst_i=1 at a clock edge, the next state SHALL be FETCH, the wait counter and instr_cnt_o SHALL clear, and err_o SHALL clear.
REQ-030 While rst_i=1, pc_write, ir_write, mem_read, mem_write, reg_write, instr_done and illegal SHALL be forced to 0 and all selects to 0.
REQ-031 Reset asserted in any state, including mid-stall or ERR, SHALL abort the instruction with no write.

Verification
REQ-032 Scenario: add (op 0, funct 100000), mem_ready_i=1 -> states 0,1,6,7,0; reg_write=1 with reg_dst=1 only in state 7; instr_cnt_o=1.
REQ-033 Scenario: lw with FETCH stalled 3 cycles -> 4 cycles in FETCH, pc_write pulses once, path 0,1,2,3,4; state 4 has mem_to_reg=1.
REQ-034 Scenario: beq with zero_i=1 -> pc_write=1 with pc_source=1 in BRANCH; same with bne -> pc_write=0.
REQ-035 Scenario: jal -> JUMP with pc_source=2, reg_dst=2, mem_to_reg=2, reg_write=1; jr (funct 001000) -> pc_source=3, reg_write=0.
REQ-036 Scenario: mem_ready_i held 0 for 16 cycles in MEMRD (WAIT_MAX=15) -> state_o=12, err_o=1 sticky; rst_i pulse -> state_o=0, err_o=0, instr_cnt_o=0.
REQ-037 Scenario: opcode 111111 -> illegal_o pulse in DECODE, no write enables, next state FETCH, instr_cnt_o+1.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
//==============================================================================
// Module      : multi_cycle_ctrl
// Description : Multi-cycle MIPS-subset control FSM. Sequences fetch, decode,
//               memory, execute, branch and jump steps, counts retired
//               instructions and traps memory stalls that last too long.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module multi_cycle_ctrl #(
   parameter int WAIT_MAX = 15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [5:0]  op_i,
   input  logic [5:0]  funct_i,
   input  logic        zero_i,
   input  logic        mem_ready_i,
   output logic        pc_write_o,
   output logic        ir_write_o,
   output logic        iord_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic        reg_write_o,
   output logic        alu_src_a_o,
   output logic [1:0]  reg_dst_o,
   output logic [1:0]  mem_to_reg_o,
   output logic [1:0]  alu_src_b_o,
   output logic [1:0]  pc_source_o,
   output logic [2:0]  alu_op_o,
   output logic [3:0]  state_o,
   output logic        instr_done_o,
   output logic        illegal_o,
   output logic        err_o,
   output logic [31:0] instr_cnt_o
);

   // Wide enough to hold WAIT_MAX; the counter never goes past it.
   localparam int                WAIT_W   = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_IEXEC  = 4'd10,
      S_IWB    = 4'd11,
      S_ERR    = 4'd12
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [WAIT_W-1:0] wait_cnt;
   logic [31:0]       instr_cnt;
   logic              mem_state;
   logic              stall_timeout;
   logic              is_jr;

   assign mem_state     = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
   // A further stall cycle with the counter already at the limit would exceed it.
   assign stall_timeout = mem_state && !mem_ready_i && (wait_cnt == WAIT_LIM);
   assign is_jr         = (op_i == OP_RTYPE) && (funct_i == FN_JR);

   assign state_o     = state;
   assign err_o       = (state == S_ERR);
   assign instr_cnt_o = instr_cnt;

   // Next-state decode and per-state datapath controls; reset blanks all controls.
   always_comb begin
      state_next   = state;
      pc_write_o   = 1'b0;
      ir_write_o   = 1'b0;
      iord_o       = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      reg_write_o  = 1'b0;
      alu_src_a_o  = 1'b0;
      reg_dst_o    = 2'd0;
      mem_to_reg_o = 2'd0;
      alu_src_b_o  = 2'd0;
      pc_source_o  = 2'd0;
      alu_op_o     = ALU_ADD;
      instr_done_o = 1'b0;
      illegal_o    = 1'b0;

      case (state)
         S_FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = 2'd1;
            if (mem_ready_i) begin
               pc_write_o = 1'b1;
               ir_write_o = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch target is computed speculatively here.
            alu_src_b_o = 2'd3;
            case (op_i)
               OP_LW, OP_SW:   state_next = S_MEMADR;
               OP_RTYPE:       state_next = (funct_i == FN_JR) ? S_JUMP : S_EXEC;
               OP_BEQ, OP_BNE: state_next = S_BRANCH;
               OP_J, OP_JAL:   state_next = S_JUMP;
               OP_ADDI:        state_next = S_IEXEC;
               default: begin
                  illegal_o    = 1'b1;
                  instr_done_o = 1'b1;
                  state_next   = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'd2;
            state_next  = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord_o     = 1'b1;
            mem_read_o = 1'b1;
            if (mem_ready_i) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 2'd1;
            instr_done_o = 1'b1;
            state_next   = S_FETCH;
         end
         S_MEMWR: begin
            iord_o      = 1'b1;
            mem_write_o = 1'b1;
            if (mem_ready_i) begin
               instr_done_o = 1'b1;
               state_next   = S_FETCH;
            end
         end
         S_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALU_FUNCT;
            state_next  = S_RWB;
         end
         S_RWB: begin
            reg_write_o  = 1'b1;
            reg_dst_o    = 2'd1;
            instr_done_o = 1'b1;
            state_next   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_o  = 1'b1;
            alu_op_o     = ALU_SUB;
            pc_source_o  = 2'd1;
            pc_write_o   = ((op_i == OP_BEQ) && zero_i) || ((op_i == OP_BNE) && !zero_i);
            instr_done_o = 1'b1;
            state_next   = S_FETCH;
         end
         S_JUMP: begin
            pc_write_o  = 1'b1;
            pc_source_o = is_jr ? 2'd3 : 2'd2;
            // jal links the already-incremented PC into r31.
            if (op_i == OP_JAL) begin
               reg_write_o  = 1'b1;
               reg_dst_o    = 2'd2;
               mem_to_reg_o = 2'd2;
            end
            instr_done_o = 1'b1;
            state_next   = S_FETCH;
         end
         S_IEXEC: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'd2;
            state_next  = S_IWB;
         end
         S_IWB: begin
            reg_write_o  = 1'b1;
            instr_done_o = 1'b1;
            state_next   = S_FETCH;
         end
         default: state_next = S_ERR;
      endcase

      if (stall_timeout) state_next = S_ERR;

      if (rst_i) begin
         pc_write_o   = 1'b0;
         ir_write_o   = 1'b0;
         iord_o       = 1'b0;
         mem_read_o   = 1'b0;
         mem_write_o  = 1'b0;
         reg_write_o  = 1'b0;
         alu_src_a_o  = 1'b0;
         reg_dst_o    = 2'd0;
         mem_to_reg_o = 2'd0;
         alu_src_b_o  = 2'd0;
         pc_source_o  = 2'd0;
         alu_op_o     = ALU_ADD;
         instr_done_o = 1'b0;
         illegal_o    = 1'b0;
      end
   end

   // State, stall counter (restarts on every state change) and retired-instruction count.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= S_FETCH;
         wait_cnt  <= '0;
         instr_cnt <= 32'd0;
      end else begin
         state <= state_next;
         if (state_next != state) begin
            wait_cnt <= '0;
         end else if (mem_state && !mem_ready_i) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
         if (instr_done_o) instr_cnt <= instr_cnt + 32'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
//==============================================================================
// Module      : tb_multi_cycle_ctrl
// Description : Self-checking bench for multi_cycle_ctrl. A path-based model
//               predicts every output each cycle; directed scenarios add
//               literal expectations on state paths and counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_multi_cycle_ctrl;

   localparam int WAIT_MAX = 15;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic [5:0]  op_i = 6'd0;
   logic [5:0]  funct_i = 6'd0;
   logic        zero_i = 1'b0;
   logic        mem_ready_i = 1'b0;
   logic        pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o;
   logic        reg_write_o, alu_src_a_o;
   logic [1:0]  reg_dst_o, mem_to_reg_o, alu_src_b_o, pc_source_o;
   logic [2:0]  alu_op_o;
   logic [3:0]  state_o;
   logic        instr_done_o, illegal_o, err_o;
   logic [31:0] instr_cnt_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multi_cycle_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .funct_i(funct_i),
      .zero_i(zero_i), .mem_ready_i(mem_ready_i),
      .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .iord_o(iord_o),
      .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o),
      .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
      .alu_src_b_o(alu_src_b_o), .pc_source_o(pc_source_o),
      .alu_op_o(alu_op_o), .state_o(state_o), .instr_done_o(instr_done_o),
      .illegal_o(illegal_o), .err_o(err_o), .instr_cnt_o(instr_cnt_o)
   );

   typedef struct packed {
      logic        pcw, irw, iord, mrd, mwr, rw, sa;
      logic [1:0]  rdst, m2r, sb, pcs;
      logic [2:0]  aop;
      logic [3:0]  st;
      logic        done, ill, err;
      logic [31:0] cnt;
   } obs_t;

   // ---------------- reference model ----------------
   // The model holds the visible state code plus the list of steps still to
   // run for the current instruction; memory steps advance only when ready.
   int          m_state = 0;
   int          m_path[$];
   int          m_stall = 0;
   logic [31:0] m_cnt = 32'd0;
   bit          m_valid = 1'b0;

   task automatic load_path(input logic [5:0] op, input logic [5:0] fn);
      m_path.delete();
      case (op)
         6'b100011: m_path = '{2, 3, 4};
         6'b101011: m_path = '{2, 5};
         6'b000000: if (fn == 6'b001000) m_path = '{9}; else m_path = '{6, 7};
         6'b000100, 6'b000101: m_path = '{8};
         6'b000010, 6'b000011: m_path = '{9};
         6'b001000: m_path = '{10, 11};
         default: m_path.delete();
      endcase
   endtask

   function automatic obs_t ctrl_for(input int s, input logic [5:0] op,
                                     input logic [5:0] fn, input logic z, input logic rdy);
      obs_t e;
      e = '0;
      case (s)
         0:  begin e.mrd = 1; e.sb = 2'd1; if (rdy) begin e.pcw = 1; e.irw = 1; end end
         1:  begin
                e.sb = 2'd3;
                if (!(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                 6'b000101, 6'b000010, 6'b000011, 6'b001000}))
                   e.ill = 1;
             end
         2:  begin e.sa = 1; e.sb = 2'd2; end
         3:  begin e.iord = 1; e.mrd = 1; end
         4:  begin e.rw = 1; e.m2r = 2'd1; end
         5:  begin e.iord = 1; e.mwr = 1; end
         6:  begin e.sa = 1; e.aop = 3'b010; end
         7:  begin e.rw = 1; e.rdst = 2'd1; end
         8:  begin
                e.sa = 1; e.aop = 3'b001; e.pcs = 2'd1;
                e.pcw = (op == 6'b000100 && z) || (op == 6'b000101 && !z);
             end
         9:  begin
                e.pcw = 1;
                e.pcs = (op == 6'b000000 && fn == 6'b001000) ? 2'd3 : 2'd2;
                if (op == 6'b000011) begin e.rw = 1; e.rdst = 2'd2; e.m2r = 2'd2; end
             end
         10: begin e.sa = 1; e.sb = 2'd2; end
         11: e.rw = 1;
         default: ;
      endcase
      return e;
   endfunction

   // Per-cycle compare of every output against the model, then model step.
   always @(negedge clk) begin
      obs_t a, e;
      int   nxt;
      a = {pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o, reg_write_o,
           alu_src_a_o, reg_dst_o, mem_to_reg_o, alu_src_b_o, pc_source_o,
           alu_op_o, state_o, instr_done_o, illegal_o, err_o, instr_cnt_o};
      if (rst_i) begin
         e = '0;
         e.st = 4'(m_state); e.err = (m_state == 12); e.cnt = m_cnt;
         if (m_valid) begin
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL cycle_compare(reset) t=%0t: actual=%h required=%h", $time, a, e);
            end
         end
         m_state = 0; m_stall = 0; m_cnt = 32'd0; m_path.delete(); m_valid = 1'b1;
      end else if (m_valid) begin
         e = ctrl_for(m_state, op_i, funct_i, zero_i, mem_ready_i);
         if (m_state == 12) begin
            nxt = 12;
         end else if (m_state == 0 || m_state == 3 || m_state == 5) begin
            if (mem_ready_i) begin
               if (m_state == 0) nxt = 1;
               else if (m_path.size() > 0) nxt = m_path.pop_front();
               else nxt = 0;
            end else begin
               nxt = m_state;
               if (m_stall + 1 > WAIT_MAX) nxt = 12;
            end
         end else begin
            if (m_state == 1) load_path(op_i, funct_i);
            if (m_path.size() > 0) nxt = m_path.pop_front();
            else nxt = 0;
         end
         e.done = (nxt == 0 && m_state != 0);
         e.st = 4'(m_state); e.err = (m_state == 12); e.cnt = m_cnt;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL cycle_compare t=%0t state=%0d: actual=%h required=%h",
                     $time, m_state, a, e);
         end
         if (nxt == m_state) m_stall++; else m_stall = 0;
         if (e.done) m_cnt = m_cnt + 32'd1;
         m_state = nxt;
      end
   end

   // ---------------- directed stimulus ----------------
   string tr, rw_s;
   int    pcw_n, ill_n, memrd_n;
   bit    got_done, hit;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk_i(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic chk_s(input string name, input string act, input string req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual=\"%s\" required=\"%s\"", name, act, req);
      end
   endtask

   // Runs one instruction from FETCH; memory is ready after 'stalls' cycles.
   task automatic run_instr(input string name, input logic [5:0] op,
                            input logic [5:0] fn, input logic z, input int stalls);
      op_i = op; funct_i = fn; zero_i = z;
      tr = ""; rw_s = ""; pcw_n = 0; ill_n = 0; got_done = 1'b0;
      for (int c = 0; c < 60 && !got_done; c++) begin
         mem_ready_i = (c >= stalls);
         @(negedge clk);
         tr = {tr, $sformatf("%0h", state_o)};
         if (pc_write_o)  pcw_n++;
         if (reg_write_o) rw_s = {rw_s, $sformatf("%0h", state_o)};
         if (illegal_o)   ill_n++;
         if (instr_done_o) got_done = 1'b1;
         tick();
      end
      chk_i({name, "_done_in_budget"}, got_done, 1);
      chk_i({name, "_back_to_fetch"}, state_o, 0);
   endtask

   initial begin
      rst_i = 1'b1;
      repeat (2) tick();
      rst_i = 1'b0;
      chk_i("reset_state", state_o, 0);
      chk_i("reset_cnt", instr_cnt_o, 0);
      chk_i("reset_err", err_o, 0);

      run_instr("add", 6'b000000, 6'b100000, 1'b0, 0);
      chk_s("add_path", tr, "0167");
      chk_s("add_rw_states", rw_s, "7");
      chk_i("add_cnt", instr_cnt_o, 1);
      chk_i("model_cnt_add", m_cnt, 1);

      run_instr("lw", 6'b100011, 6'b000000, 1'b0, 3);
      chk_s("lw_stall3_path", tr, "00001234");
      chk_i("lw_pcw_pulses", pcw_n, 1);
      chk_s("lw_rw_states", rw_s, "4");

      run_instr("sw", 6'b101011, 6'b000000, 1'b0, 0);
      chk_s("sw_path", tr, "0125");
      chk_s("sw_rw_states", rw_s, "");

      run_instr("beq", 6'b000100, 6'b000000, 1'b1, 0);
      chk_s("beq_path", tr, "018");
      chk_i("beq_taken_pcw", pcw_n, 2);

      run_instr("bne", 6'b000101, 6'b000000, 1'b1, 0);
      chk_i("bne_not_taken_pcw", pcw_n, 1);

      run_instr("jal", 6'b000011, 6'b000000, 1'b0, 0);
      chk_s("jal_path", tr, "019");
      chk_s("jal_rw_states", rw_s, "9");

      run_instr("jr", 6'b000000, 6'b001000, 1'b0, 0);
      chk_s("jr_path", tr, "019");
      chk_s("jr_rw_states", rw_s, "");

      run_instr("j", 6'b000010, 6'b000000, 1'b0, 0);
      chk_s("j_path", tr, "019");

      run_instr("addi", 6'b001000, 6'b000000, 1'b0, 0);
      chk_s("addi_path", tr, "01ab");
      chk_s("addi_rw_states", rw_s, "b");

      run_instr("illegal", 6'b111111, 6'b000000, 1'b0, 0);
      chk_s("illegal_path", tr, "01");
      chk_i("illegal_pulses", ill_n, 1);
      chk_s("illegal_rw_states", rw_s, "");
      chk_i("illegal_cnt", instr_cnt_o, 10);

      // Exactly WAIT_MAX stalls is still tolerated.
      run_instr("lw_stall15", 6'b100011, 6'b000000, 1'b0, 15);
      chk_s("lw_stall15_path", tr, "00000000000000001234");
      chk_i("lw_stall15_err", err_o, 0);
      chk_i("lw_stall15_cnt", instr_cnt_o, 11);

      // Reset in the middle of a fetch stall.
      op_i = 6'b100011; mem_ready_i = 1'b0;
      repeat (5) tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk_i("midstall_reset_state", state_o, 0);
      chk_i("midstall_reset_cnt", instr_cnt_o, 0);

      // lw whose read never completes: 16 stalled cycles in MEMRD trap to ERR.
      op_i = 6'b100011; mem_ready_i = 1'b1;
      tick();
      mem_ready_i = 1'b0;
      memrd_n = 0; hit = 1'b0;
      for (int c = 0; c < 40 && !hit; c++) begin
         @(negedge clk);
         if (state_o == 4'd3)  memrd_n++;
         if (state_o == 4'd12) hit = 1'b1;
         tick();
      end
      chk_i("err_reached", hit, 1);
      chk_i("memrd_stall_cycles", memrd_n, 16);
      mem_ready_i = 1'b1;
      repeat (4) tick();
      chk_i("err_sticky_state", state_o, 12);
      chk_i("err_sticky_flag", err_o, 1);
      chk_i("err_no_retire", instr_cnt_o, 0);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk_i("err_reset_state", state_o, 0);
      chk_i("err_reset_flag", err_o, 0);
      chk_i("err_reset_cnt", instr_cnt_o, 0);

      run_instr("add_after_err", 6'b000000, 6'b100010, 1'b0, 1);
      chk_s("add_after_err_path", tr, "00167");
      chk_i("add_after_err_cnt", instr_cnt_o, 1);

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
